// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between fetch_ctrl and instruction memory.
// Single-outstanding request/grant/response handshake.
interface fetch_ctrl_if #(
   parameter int WIDTH = 32
);

   logic             imem_req_out;
   logic [WIDTH-1:0] imem_addr_out;
   logic             imem_gnt_in;
   logic             imem_rvalid_in;
   logic [31:0]      imem_rdata_in;

   modport master (
      output imem_req_out,
      output imem_addr_out,
      input  imem_gnt_in,
      input  imem_rvalid_in,
      input  imem_rdata_in
   );

   modport slave (
      input  imem_req_out,
      input  imem_addr_out,
      output imem_gnt_in,
      output imem_rvalid_in,
      output imem_rdata_in
   );

endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencing controller.
// Selects the next PC, runs a single-outstanding request to instruction
// memory, and presents fetched instructions to decode through a one-entry
// output register with stall back-pressure. Redirects flush in-flight and
// buffered instructions.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect holds
// the PC and pulses misalign_out instead of aligning the target).
module fetch_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [WIDTH-1:0]   pc_current_in,
   input  logic [WIDTH-1:0]   pc_plus4_in,
   output logic [WIDTH-1:0]   pc_next_out,
   input  logic               redirect_in,
   input  logic [WIDTH-1:0]   redirect_pc_in,
   input  logic               stall_in,
   fetch_ctrl_if.master       imem,
   output logic               instr_valid_out,
   output logic [31:0]        instr_out,
   output logic [WIDTH-1:0]   instr_pc_out,
   output logic               misalign_out
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             kill_q;
   logic [WIDTH-1:0] req_pc_q;

   logic             slot_free;
   logic             redirect_act;
   logic             req;
   logic             grant;
   logic             resp;
   logic             load;
   logic             consume;
   logic [WIDTH-1:0] redirect_target;

   assign slot_free     = !instr_valid_out || !stall_in;
   assign redirect_act  = redirect_in && (state_q != IDLE);
   assign grant         = req && imem.imem_gnt_in;
   assign resp          = (state_q == WAIT) && imem.imem_rvalid_in;
   assign load          = resp && !kill_q && !redirect_in;
   assign consume       = instr_valid_out && !stall_in;

   assign imem.imem_req_out  = req;
   assign imem.imem_addr_out = pc_current_in;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned      = (redirect_pc_in[1:0] != 2'b00);
   assign redirect_target = misaligned ? pc_current_in : redirect_pc_in;
`else
   assign redirect_target = redirect_pc_in & ~{{(WIDTH-2){1'b0}}, 2'b11};
`endif

   // State register: reset parks the controller in IDLE, abandoning any request
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a redirect in REQ suppresses the request so we stay put
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = REQ;
         REQ:     if (grant) state_d = WAIT;
         WAIT:    if (imem.imem_rvalid_in) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: request gating and PC select (reset > redirect > advance > hold)
   always_comb begin
      req         = 1'b0;
      pc_next_out = pc_current_in;
      if (rst_in) begin
         pc_next_out = RESET_PC;
      end else begin
         if (state_q == REQ) begin
            req = slot_free && !redirect_in;
         end
         if (redirect_act) begin
            pc_next_out = redirect_target;
         end else if (grant) begin
            pc_next_out = pc_plus4_in;
         end
      end
   end

   // Request bookkeeping: remember the granted PC and whether to drop its response
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         kill_q   <= 1'b0;
         req_pc_q <= '0;
      end else begin
         if (grant) begin
            req_pc_q <= pc_current_in;
         end
         if (resp) begin
            kill_q <= 1'b0;
         end else if (redirect_in && (state_q == WAIT)) begin
            kill_q <= 1'b1;
         end
      end
   end

   // Output register: redirect flushes even under stall, load wins over consume
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         instr_valid_out <= 1'b0;
         instr_out       <= '0;
         instr_pc_out    <= '0;
      end else begin
         if (load) begin
            instr_out    <= imem.imem_rdata_in;
            instr_pc_out <= req_pc_q;
         end
         if (redirect_act) begin
            instr_valid_out <= 1'b0;
         end else if (load) begin
            instr_valid_out <= 1'b1;
         end else if (consume) begin
            instr_valid_out <= 1'b0;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Misalign flag: one-cycle pulse after a misaligned redirect
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         misalign_out <= 1'b0;
      end else begin
         misalign_out <= redirect_act && misaligned;
      end
   end
`else
   assign misalign_out = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a small IF-stage PC model and an
// expected-instruction scoreboard. Honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pc_current;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misalign;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];

   fetch_ctrl_if #(.WIDTH(32)) imem ();

   fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .pc_current_in   (pc_current),
      .pc_plus4_in     (pc_plus4),
      .pc_next_out     (pc_next),
      .redirect_in     (redirect),
      .redirect_pc_in  (redirect_pc),
      .stall_in        (stall),
      .imem            (imem.master),
      .instr_valid_out (instr_valid),
      .instr_out       (instr),
      .instr_pc_out    (instr_pc),
      .misalign_out    (misalign)
   );

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // IF-stage PC register model fed by the controller
   always @(posedge clk) begin
      pc_current <= pc_next;
   end

   assign pc_plus4 = pc_current + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [31:0] MIS_PC  = 32'h0000_0204;
   localparam logic        MIS_BIT = 1'b1;
`else
   localparam logic [31:0] MIS_PC  = 32'h0000_0100;
   localparam logic        MIS_BIT = 1'b0;
`endif

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rdpc,
                                input logic st, input logic g, input logic rv,
                                input logic [31:0] rdata);
      rst                 = r;
      redirect            = rd;
      redirect_pc         = rdpc;
      stall               = st;
      imem.imem_gnt_in    = g;
      imem.imem_rvalid_in = rv;
      imem.imem_rdata_in  = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expectLoad(input logic [31:0] i, input logic [31:0] p);
      exp_t e;
      e.instr = i;
      e.pc    = p;
      sb_q.push_back(e);
   endtask

   task automatic popCheck(input string tag);
      exp_t e;
      total++;
      assert (sb_q.size() > 0) else begin
         bad++;
         $error("[TB] FAIL %s_sb_empty observed=0 expected=1", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
         checkOutput({tag, "_instr"}, instr, e.instr);
         checkOutput({tag, "_pc"}, instr_pc, e.pc);
      end
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      nextCycle();
      nextCycle();
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_ipc", instr_pc, 32'd0);
      checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
      checkOutput("rst_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("rst_pc_next", pc_next, 32'd0);

      // IDLE cycle after reset release
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("idle_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("idle_pc_next", pc_next, 32'd0);

      // First request granted immediately
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("req0_req", {31'd0, imem.imem_req_out}, 32'd1);
      checkOutput("req0_addr", imem.imem_addr_out, 32'h0);
      checkOutput("req0_pc_next", pc_next, 32'h4);

      // Response next cycle
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0013);
      expectLoad(32'h0000_0013, 32'h0);
      checkOutput("wait0_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("wait0_pc_next", pc_next, 32'h4);

      // Stall with a valid instruction: no request, PC holds
      nextCycle();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      popCheck("load0");
      checkOutput("stall_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("stall_pc_next", pc_next, 32'h4);

      nextCycle();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("stall_hold_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stall_hold_instr", instr, 32'h0000_0013);

      // Release stall: request for 0x4 the same cycle
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("unstall_req", {31'd0, imem.imem_req_out}, 32'd1);
      checkOutput("unstall_addr", imem.imem_addr_out, 32'h4);
      checkOutput("unstall_pc_next", pc_next, 32'h8);

      // Redirect in WAIT before the response arrives
      nextCycle();
      applyStimulus(0, 1, 32'h100, 0, 0, 0, 0);
      checkOutput("consume_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("redir_wait_pc_next", pc_next, 32'h100);
      checkOutput("redir_wait_req", {31'd0, imem.imem_req_out}, 32'd0);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      checkOutput("killed_pc_next", pc_next, 32'h100);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("killed_drop_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("after_kill_req", {31'd0, imem.imem_req_out}, 32'd1);
      checkOutput("after_kill_addr", imem.imem_addr_out, 32'h100);
      checkOutput("after_kill_pc_next", pc_next, 32'h104);

      // Kill cleared: this response must be accepted
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h00A0_0093);
      expectLoad(32'h00A0_0093, 32'h100);

      // Redirect while a buffered instruction is stalled
      nextCycle();
      applyStimulus(0, 1, 32'h200, 1, 0, 0, 0);
      popCheck("load1");
      checkOutput("redir_stall_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("redir_stall_pc_next", pc_next, 32'h200);

      nextCycle();
      applyStimulus(0, 0, 0, 1, 1, 0, 0);
      checkOutput("redir_flush_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("redir_fetch_req", {31'd0, imem.imem_req_out}, 32'd1);
      checkOutput("redir_fetch_addr", imem.imem_addr_out, 32'h200);
      checkOutput("redir_fetch_pc_next", pc_next, 32'h204);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0011);
      expectLoad(32'h0000_0011, 32'h200);

      // Misaligned redirect to 0x102
      nextCycle();
      applyStimulus(0, 1, 32'h102, 0, 0, 0, 0);
      popCheck("load2");
      checkOutput("mis_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("mis_pc_next", pc_next, MIS_PC);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("mis_flag", {31'd0, misalign}, {31'd0, MIS_BIT});
      checkOutput("mis_flush_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("mis_addr", imem.imem_addr_out, MIS_PC);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("mis_flag_clear", {31'd0, misalign}, 32'd0);
      checkOutput("mis_fetch_req", {31'd0, imem.imem_req_out}, 32'd1);
      checkOutput("mis_fetch_pc_next", pc_next, MIS_PC + 32'd4);

      // Reset asserted mid-WAIT
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_wait_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("rst_wait_pc_next", pc_next, 32'h0);

      // Stale response in IDLE and REQ is ignored
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
      checkOutput("stale_idle_req", {31'd0, imem.imem_req_out}, 32'd0);
      checkOutput("stale_idle_pc_next", pc_next, 32'h0);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
      checkOutput("stale_idle_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("stale_req_req", {31'd0, imem.imem_req_out}, 32'd1);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("stale_req_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("post_rst_addr", imem.imem_addr_out, 32'h0);
      checkOutput("post_rst_pc_next", pc_next, 32'h4);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_002A);
      expectLoad(32'h0000_002A, 32'h0);

      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      popCheck("load3");

      checkOutput("sb_drained", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
